alu_issue_ctrl: RTL and testbench

Issue/writeback controller that sits on the driving side of the LC-3 datapath ALU. It accepts one operate instruction (ADD, AND, NOT) at a time over a valid/ready handshake and holds an 8×16 general-purpose register file. It presents operands and the 2-bit function select to the ALU, captures the ALU result, writes it back to the destination register and updates the NZP condition codes.

---
 rtl/alu_issue_ctrl.sv | 121 ++++++++++++
 tb/tb_alu_issue_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller for the LC-3 operate instructions (ADD, AND, NOT).
// Holds R0-R7, drives the ALU operands/function and retires results with NZP update.
module alu_issue_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] instr,
   input  logic        instr_valid,
   output logic        instr_ready,
   input  logic        init_we,
   input  logic [2:0]  init_addr,
   input  logic [15:0] init_data,
   input  logic [2:0]  rd_addr,
   output logic [15:0] rd_data,
   output logic [15:0] regA,
   output logic [15:0] regB,
   output logic [1:0]  ALUK,
   input  logic [15:0] ALU,
   output logic        done,
   output logic        illegal,
   output logic [2:0]  nzp
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DECODE = 2'd1,
      EXEC   = 2'd2,
      WB     = 2'd3
   } state_t;

   state_t      state, state_nx;
   logic [15:0] instr_q;
   logic [15:0] result;
   logic [15:0] rf [8];

   logic [3:0]  op;
   logic [2:0]  dr, sr1, sr2;
   logic        op_add, op_and, op_not, legal;
   logic [15:0] imm_sx;

   assign op     = instr_q[15:12];
   assign dr     = instr_q[11:9];
   assign sr1    = instr_q[8:6];
   assign sr2    = instr_q[2:0];
   assign imm_sx = {{11{instr_q[4]}}, instr_q[4:0]};
   assign op_add = (op == 4'b0001);
   assign op_and = (op == 4'b0101);
   assign op_not = (op == 4'b1001);
   assign legal  = op_add | op_and | op_not;

   assign rd_data = rf[rd_addr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx    = state;
      instr_ready = 1'b0;
      done        = 1'b0;
      illegal     = 1'b0;
      case (state)
         IDLE: begin
            instr_ready = 1'b1;
            if (instr_valid) state_nx = DECODE;
         end
         DECODE: state_nx = EXEC;
         EXEC:   state_nx = WB;
         WB: begin
            done     = legal;
            illegal  = ~legal;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Preload lands at the same edge as the handshake, so DECODE sees the new value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < 8; i++) rf[i] <= '0;
         instr_q <= '0;
         result  <= '0;
         regA    <= '0;
         regB    <= '0;
         ALUK    <= 2'b11;
         nzp     <= 3'b010;
      end else begin
         case (state)
            IDLE: begin
               if (init_we)     rf[init_addr] <= init_data;
               if (instr_valid) instr_q       <= instr;
            end
            DECODE: begin
               if (legal) begin
                  regA <= rf[sr1];
                  if (op_not)          regB <= '0;
                  else if (instr_q[5]) regB <= imm_sx;
                  else                 regB <= rf[sr2];
               end
               if (op_add)      ALUK <= 2'b00;
               else if (op_and) ALUK <= 2'b01;
               else if (op_not) ALUK <= 2'b10;
               else             ALUK <= 2'b11;
            end
            EXEC: result <= ALU;
            WB: begin
               ALUK <= 2'b11;
               if (legal) begin
                  rf[dr] <= result;
                  if (result[15])        nzp <= 3'b100;
                  else if (result == '0) nzp <= 3'b010;
                  else                   nzp <= 3'b001;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural LC-3 ALU on the result path.
module tb_alu_issue_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] instr;
   logic        instr_valid;
   logic        instr_ready;
   logic        init_we;
   logic [2:0]  init_addr;
   logic [15:0] init_data;
   logic [2:0]  rd_addr;
   logic [15:0] rd_data;
   logic [15:0] regA, regB;
   logic [1:0]  ALUK;
   logic [15:0] ALU;
   logic        done, illegal;
   logic [2:0]  nzp;

   int checks = 0;
   int errors = 0;
   int acc;

   always #5 clk = ~clk;

   alu_issue_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .init_we(init_we), .init_addr(init_addr), .init_data(init_data),
      .rd_addr(rd_addr), .rd_data(rd_data),
      .regA(regA), .regB(regB), .ALUK(ALUK), .ALU(ALU),
      .done(done), .illegal(illegal), .nzp(nzp)
   );

   always_comb begin
      case (ALUK)
         2'b00:   ALU = regA + regB;
         2'b01:   ALU = regA & regB;
         2'b10:   ALU = ~regA;
         default: ALU = regA;
      endcase
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic preload(input logic [2:0] a, input logic [15:0] d);
      @(negedge clk);
      init_we = 1'b1; init_addr = a; init_data = d;
      @(posedge clk); #1;
      init_we = 1'b0;
   endtask

   task automatic read_reg(input string tag, input logic [2:0] a, input logic [15:0] exp);
      rd_addr = a;
      #1;
      check(tag, rd_data, exp);
   endtask

   // Issue one instruction and step through DECODE/EXEC/WB checking each cycle.
   task automatic run_op(input string tag, input logic [15:0] ins, input logic [2:0] dr,
                         input logic [15:0] exp, input logic [2:0] exp_nzp,
                         input logic lgl, input logic [1:0] exp_aluk);
      @(negedge clk);
      instr = ins; instr_valid = 1'b1;
      check({tag, "_ready"}, {15'd0, instr_ready}, 16'd1);
      @(posedge clk); #1;
      instr_valid = 1'b0;
      check({tag, "_dec_done"}, {15'd0, done}, 16'd0);
      check({tag, "_dec_busy"}, {15'd0, instr_ready}, 16'd0);
      @(posedge clk); #1;
      check({tag, "_aluk"}, {14'd0, ALUK}, {14'd0, exp_aluk});
      check({tag, "_exec_done"}, {15'd0, done}, 16'd0);
      @(posedge clk); #1;
      check({tag, "_wb_done"}, {15'd0, done}, {15'd0, lgl});
      check({tag, "_wb_illegal"}, {15'd0, illegal}, {15'd0, ~lgl});
      @(posedge clk); #1;
      check({tag, "_post_done"}, {15'd0, done}, 16'd0);
      check({tag, "_post_aluk"}, {14'd0, ALUK}, 16'd3);
      check({tag, "_nzp"}, {13'd0, nzp}, {13'd0, exp_nzp});
      read_reg({tag, "_rd"}, dr, exp);
   endtask

   initial begin
      rst_n = 1'b0; instr = '0; instr_valid = 1'b0;
      init_we = 1'b0; init_addr = '0; init_data = '0; rd_addr = '0;
      #12;
      for (int i = 0; i < 8; i++) read_reg("reset_rf", 3'(i), 16'h0000);
      check("reset_nzp", {13'd0, nzp}, 16'h0002);
      check("reset_aluk", {14'd0, ALUK}, 16'h0003);
      check("reset_ready", {15'd0, instr_ready}, 16'h0001);
      check("reset_rega", regA, 16'h0000);
      check("reset_regb", regB, 16'h0000);
      check("reset_done", {15'd0, done}, 16'h0000);
      @(negedge clk); rst_n = 1'b1;

      preload(3'd1, 16'h0005);
      preload(3'd2, 16'hFFFD);
      read_reg("preload_r2", 3'd2, 16'hFFFD);
      run_op("add_rr", 16'h1642, 3'd3, 16'h0002, 3'b001, 1'b1, 2'b00);
      check("add_rr_rega", regA, 16'h0005);
      check("add_rr_regb", regB, 16'hFFFD);
      run_op("and_imm0", 16'h5860, 3'd4, 16'h0000, 3'b010, 1'b1, 2'b01);
      run_op("add_neg16", 16'h1A70, 3'd5, 16'hFFF5, 3'b100, 1'b1, 2'b00);
      check("add_neg16_regb", regB, 16'hFFF0);
      run_op("not_r1", 16'h927F, 3'd1, 16'hFFFA, 3'b100, 1'b1, 2'b10);
      check("not_regb", regB, 16'h0000);
      check("not_rega", regA, 16'h0005);
      // ADD R2,R2,R1: both operands read before R2 is overwritten
      run_op("add_dr_sr", 16'h1481, 3'd2, 16'hFFF7, 3'b100, 1'b1, 2'b00);

      preload(3'd6, 16'h7FFF);
      run_op("add_wrap", 16'h1DA1, 3'd6, 16'h8000, 3'b100, 1'b1, 2'b00);
      run_op("illegal", 16'h0000, 3'd0, 16'h0000, 3'b100, 1'b0, 2'b11);
      check("illegal_rega", regA, 16'h7FFF);
      check("illegal_regb", regB, 16'h0001);
      read_reg("illegal_r6", 3'd6, 16'h8000);

      // Preload and handshake in the same cycle: ADD R7,R7,#1 sees R7=3
      @(negedge clk);
      init_we = 1'b1; init_addr = 3'd7; init_data = 16'h0003;
      instr = 16'h1FE1; instr_valid = 1'b1;
      @(posedge clk); #1;
      init_we = 1'b0; instr_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      read_reg("same_cycle_r7", 3'd7, 16'h0004);
      check("same_cycle_nzp", {13'd0, nzp}, 16'h0001);

      // Held instr_valid: ADD R4,R4,#1 accepted once per 4 cycles
      acc = 0;
      @(negedge clk);
      instr = 16'h1921; instr_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (i > 0) @(negedge clk);
         if (instr_ready) acc++;
         @(posedge clk);
      end
      #1;
      instr_valid = 1'b0;
      check("held_accepts", 16'(acc), 16'd2);
      read_reg("held_r4", 3'd4, 16'h0002);
      check("held_ready", {15'd0, instr_ready}, 16'd1);

      // Reset during EXEC abandons the instruction
      @(negedge clk);
      instr = 16'h1921; instr_valid = 1'b1;
      @(posedge clk); #1;
      instr_valid = 1'b0;
      @(posedge clk); #1;
      check("pre_rst_aluk", {14'd0, ALUK}, 16'h0000);
      rst_n = 1'b0;
      #1;
      check("rst_exec_aluk", {14'd0, ALUK}, 16'h0003);
      check("rst_exec_rega", regA, 16'h0000);
      check("rst_exec_regb", regB, 16'h0000);
      check("rst_exec_nzp", {13'd0, nzp}, 16'h0002);
      check("rst_exec_ready", {15'd0, instr_ready}, 16'h0001);
      read_reg("rst_exec_r4", 3'd4, 16'h0000);
      @(negedge clk); rst_n = 1'b1;
      acc = 0;
      repeat (4) begin
         @(negedge clk);
         if (done) acc++;
      end
      check("rst_exec_no_done", 16'(acc), 16'd0);
      read_reg("rst_exec_r4_after", 3'd4, 16'h0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
